// File: rtl/round_key_server.sv
// AES-128 round-key server: expands a loaded cipher key one round per clock into an
// 11-entry register file and answers combinational {valid, round_key} lookups by index.
module round_key_server #(
    parameter int unsigned NR       = 10,
    parameter bit          BYTE_REV = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] cipher_key,
    input  logic [3:0]   Addr,
    output logic [128:0] Key,
    output logic         busy,
    output logic         keys_ready
);

    localparam int unsigned KW = 128;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST = CW'(NR);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic [KW-1:0]   keys_q [0:NR];
    logic [KW-1:0]   keys_d [0:NR];
    logic [NR:0]     valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    function automatic logic [7:0] sbox(input logic [7:0] i);
        logic [7:0] o;
        o = 8'h00;
        case (i)
            8'h00: o=8'h63; 8'h01: o=8'h7c; 8'h02: o=8'h77; 8'h03: o=8'h7b; 8'h04: o=8'hf2; 8'h05: o=8'h6b; 8'h06: o=8'h6f; 8'h07: o=8'hc5;
            8'h08: o=8'h30; 8'h09: o=8'h01; 8'h0a: o=8'h67; 8'h0b: o=8'h2b; 8'h0c: o=8'hfe; 8'h0d: o=8'hd7; 8'h0e: o=8'hab; 8'h0f: o=8'h76;
            8'h10: o=8'hca; 8'h11: o=8'h82; 8'h12: o=8'hc9; 8'h13: o=8'h7d; 8'h14: o=8'hfa; 8'h15: o=8'h59; 8'h16: o=8'h47; 8'h17: o=8'hf0;
            8'h18: o=8'had; 8'h19: o=8'hd4; 8'h1a: o=8'ha2; 8'h1b: o=8'haf; 8'h1c: o=8'h9c; 8'h1d: o=8'ha4; 8'h1e: o=8'h72; 8'h1f: o=8'hc0;
            8'h20: o=8'hb7; 8'h21: o=8'hfd; 8'h22: o=8'h93; 8'h23: o=8'h26; 8'h24: o=8'h36; 8'h25: o=8'h3f; 8'h26: o=8'hf7; 8'h27: o=8'hcc;
            8'h28: o=8'h34; 8'h29: o=8'ha5; 8'h2a: o=8'he5; 8'h2b: o=8'hf1; 8'h2c: o=8'h71; 8'h2d: o=8'hd8; 8'h2e: o=8'h31; 8'h2f: o=8'h15;
            8'h30: o=8'h04; 8'h31: o=8'hc7; 8'h32: o=8'h23; 8'h33: o=8'hc3; 8'h34: o=8'h18; 8'h35: o=8'h96; 8'h36: o=8'h05; 8'h37: o=8'h9a;
            8'h38: o=8'h07; 8'h39: o=8'h12; 8'h3a: o=8'h80; 8'h3b: o=8'he2; 8'h3c: o=8'heb; 8'h3d: o=8'h27; 8'h3e: o=8'hb2; 8'h3f: o=8'h75;
            8'h40: o=8'h09; 8'h41: o=8'h83; 8'h42: o=8'h2c; 8'h43: o=8'h1a; 8'h44: o=8'h1b; 8'h45: o=8'h6e; 8'h46: o=8'h5a; 8'h47: o=8'ha0;
            8'h48: o=8'h52; 8'h49: o=8'h3b; 8'h4a: o=8'hd6; 8'h4b: o=8'hb3; 8'h4c: o=8'h29; 8'h4d: o=8'he3; 8'h4e: o=8'h2f; 8'h4f: o=8'h84;
            8'h50: o=8'h53; 8'h51: o=8'hd1; 8'h52: o=8'h00; 8'h53: o=8'hed; 8'h54: o=8'h20; 8'h55: o=8'hfc; 8'h56: o=8'hb1; 8'h57: o=8'h5b;
            8'h58: o=8'h6a; 8'h59: o=8'hcb; 8'h5a: o=8'hbe; 8'h5b: o=8'h39; 8'h5c: o=8'h4a; 8'h5d: o=8'h4c; 8'h5e: o=8'h58; 8'h5f: o=8'hcf;
            8'h60: o=8'hd0; 8'h61: o=8'hef; 8'h62: o=8'haa; 8'h63: o=8'hfb; 8'h64: o=8'h43; 8'h65: o=8'h4d; 8'h66: o=8'h33; 8'h67: o=8'h85;
            8'h68: o=8'h45; 8'h69: o=8'hf9; 8'h6a: o=8'h02; 8'h6b: o=8'h7f; 8'h6c: o=8'h50; 8'h6d: o=8'h3c; 8'h6e: o=8'h9f; 8'h6f: o=8'ha8;
            8'h70: o=8'h51; 8'h71: o=8'ha3; 8'h72: o=8'h40; 8'h73: o=8'h8f; 8'h74: o=8'h92; 8'h75: o=8'h9d; 8'h76: o=8'h38; 8'h77: o=8'hf5;
            8'h78: o=8'hbc; 8'h79: o=8'hb6; 8'h7a: o=8'hda; 8'h7b: o=8'h21; 8'h7c: o=8'h10; 8'h7d: o=8'hff; 8'h7e: o=8'hf3; 8'h7f: o=8'hd2;
            8'h80: o=8'hcd; 8'h81: o=8'h0c; 8'h82: o=8'h13; 8'h83: o=8'hec; 8'h84: o=8'h5f; 8'h85: o=8'h97; 8'h86: o=8'h44; 8'h87: o=8'h17;
            8'h88: o=8'hc4; 8'h89: o=8'ha7; 8'h8a: o=8'h7e; 8'h8b: o=8'h3d; 8'h8c: o=8'h64; 8'h8d: o=8'h5d; 8'h8e: o=8'h19; 8'h8f: o=8'h73;
            8'h90: o=8'h60; 8'h91: o=8'h81; 8'h92: o=8'h4f; 8'h93: o=8'hdc; 8'h94: o=8'h22; 8'h95: o=8'h2a; 8'h96: o=8'h90; 8'h97: o=8'h88;
            8'h98: o=8'h46; 8'h99: o=8'hee; 8'h9a: o=8'hb8; 8'h9b: o=8'h14; 8'h9c: o=8'hde; 8'h9d: o=8'h5e; 8'h9e: o=8'h0b; 8'h9f: o=8'hdb;
            8'ha0: o=8'he0; 8'ha1: o=8'h32; 8'ha2: o=8'h3a; 8'ha3: o=8'h0a; 8'ha4: o=8'h49; 8'ha5: o=8'h06; 8'ha6: o=8'h24; 8'ha7: o=8'h5c;
            8'ha8: o=8'hc2; 8'ha9: o=8'hd3; 8'haa: o=8'hac; 8'hab: o=8'h62; 8'hac: o=8'h91; 8'had: o=8'h95; 8'hae: o=8'he4; 8'haf: o=8'h79;
            8'hb0: o=8'he7; 8'hb1: o=8'hc8; 8'hb2: o=8'h37; 8'hb3: o=8'h6d; 8'hb4: o=8'h8d; 8'hb5: o=8'hd5; 8'hb6: o=8'h4e; 8'hb7: o=8'ha9;
            8'hb8: o=8'h6c; 8'hb9: o=8'h56; 8'hba: o=8'hf4; 8'hbb: o=8'hea; 8'hbc: o=8'h65; 8'hbd: o=8'h7a; 8'hbe: o=8'hae; 8'hbf: o=8'h08;
            8'hc0: o=8'hba; 8'hc1: o=8'h78; 8'hc2: o=8'h25; 8'hc3: o=8'h2e; 8'hc4: o=8'h1c; 8'hc5: o=8'ha6; 8'hc6: o=8'hb4; 8'hc7: o=8'hc6;
            8'hc8: o=8'he8; 8'hc9: o=8'hdd; 8'hca: o=8'h74; 8'hcb: o=8'h1f; 8'hcc: o=8'h4b; 8'hcd: o=8'hbd; 8'hce: o=8'h8b; 8'hcf: o=8'h8a;
            8'hd0: o=8'h70; 8'hd1: o=8'h3e; 8'hd2: o=8'hb5; 8'hd3: o=8'h66; 8'hd4: o=8'h48; 8'hd5: o=8'h03; 8'hd6: o=8'hf6; 8'hd7: o=8'h0e;
            8'hd8: o=8'h61; 8'hd9: o=8'h35; 8'hda: o=8'h57; 8'hdb: o=8'hb9; 8'hdc: o=8'h86; 8'hdd: o=8'hc1; 8'hde: o=8'h1d; 8'hdf: o=8'h9e;
            8'he0: o=8'he1; 8'he1: o=8'hf8; 8'he2: o=8'h98; 8'he3: o=8'h11; 8'he4: o=8'h69; 8'he5: o=8'hd9; 8'he6: o=8'h8e; 8'he7: o=8'h94;
            8'he8: o=8'h9b; 8'he9: o=8'h1e; 8'hea: o=8'h87; 8'heb: o=8'he9; 8'hec: o=8'hce; 8'hed: o=8'h55; 8'hee: o=8'h28; 8'hef: o=8'hdf;
            8'hf0: o=8'h8c; 8'hf1: o=8'ha1; 8'hf2: o=8'h89; 8'hf3: o=8'h0d; 8'hf4: o=8'hbf; 8'hf5: o=8'he6; 8'hf6: o=8'h42; 8'hf7: o=8'h68;
            8'hf8: o=8'h41; 8'hf9: o=8'h99; 8'hfa: o=8'h2d; 8'hfb: o=8'h0f; 8'hfc: o=8'hb0; 8'hfd: o=8'h54; 8'hfe: o=8'hbb; 8'hff: o=8'h16;
            default: o = 8'h00;
        endcase
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [CW-1:0] r);
        logic [7:0] c;
        c = 8'h00;
        case (r)
            4'd1: c = 8'h01;  4'd2: c = 8'h02;  4'd3: c = 8'h04;  4'd4: c = 8'h08;  4'd5: c = 8'h10;
            4'd6: c = 8'h20;  4'd7: c = 8'h40;  4'd8: c = 8'h80;  4'd9: c = 8'h1b;  4'd10: c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [KW-1:0] next_round(input logic [KW-1:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [KW-1:0] byte_rev(input logic [KW-1:0] k);
        logic [KW-1:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = k[(15-b)*8 +: 8];
        return r;
    endfunction

    // Load/expand sequencing; a load is only honoured outside EXPAND.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        keys_d  = keys_q;
        valid_d = valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    keys_d[0] = cipher_key;
                    valid_d   = (NR+1)'(1);
                    rcnt_d    = CW'(1);
                    state_d   = EXPAND;
                end
            end
            EXPAND: begin
                keys_d[rcnt_q]  = next_round(keys_q[rcnt_q - CW'(1)], rcon(rcnt_q));
                valid_d[rcnt_q] = 1'b1;
                rcnt_d          = rcnt_q + CW'(1);
                if (rcnt_q == LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == EXPAND);
        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            keys_q  <= '{default: '0};
            valid_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            keys_q  <= keys_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Lookup is combinational so the core sees a key in the same cycle it asks.
    always_comb begin
        Key = '0;
        if (Addr <= LAST && valid_q[Addr])
            Key = {1'b1, BYTE_REV ? byte_rev(keys_q[Addr]) : keys_q[Addr]};
    end

    assign busy       = busy_q;
    assign keys_ready = ready_q;

endmodule

// File: tb/tb_round_key_server.sv
// Scoreboard bench for round_key_server: one FIPS-order and one byte-reversed instance
// checked against an independently derived key-expansion model.
module tb_round_key_server;

    logic         clk = 1'b0;
    logic         rst;
    logic         load0, load1;
    logic [127:0] key0, key1;
    logic [3:0]   addr;
    logic [128:0] kout0, kout1;
    logic         busy0, busy1, rdy0, rdy1;

    round_key_server #(.NR(10), .BYTE_REV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load(load0), .cipher_key(key0), .Addr(addr),
        .Key(kout0), .busy(busy0), .keys_ready(rdy0));

    round_key_server #(.NR(10), .BYTE_REV(1'b1)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .cipher_key(key1), .Addr(addr),
        .Key(kout1), .busy(busy1), .keys_ready(rdy1));

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    sb [0:255];
    logic [127:0]  mdl [0:1][0:10];
    logic [128:0]  exp_q [$];

    task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return gmul_ret(p);
    endfunction

    function automatic logic [7:0] gmul_ret(input logic [7:0] p);
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input int sel, input logic [127:0] k);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc = 8'h01;
        mdl[sel][0] = k;
        for (int r = 1; r <= 10; r++) begin
            {w0, w1, w2, w3} = mdl[sel][r-1];
            t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h0};
            w0 = w0 ^ t;  w1 = w1 ^ w0;  w2 = w2 ^ w1;  w3 = w3 ^ w2;
            mdl[sel][r] = {w0, w1, w2, w3};
            rc = gmul(rc, 8'h02);
        end
    endtask

    function automatic logic [127:0] brev(input logic [127:0] k);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = k[(15-b)*8 +: 8];
        return r;
    endfunction

    function automatic logic [128:0] exp_key(input int sel, input int a);
        if (a > 10) return '0;
        return {1'b1, (sel == 1) ? brev(mdl[sel][a]) : mdl[sel][a]};
    endfunction

    function automatic logic [128:0] dut_key(input int sel);
        return (sel == 1) ? kout1 : kout0;
    endfunction

    // Sweep every index; expectations are queued on the drive and popped on the sample.
    task automatic sweep(input int sel, input bit vld, input string tag);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            exp_q.push_back(vld ? exp_key(sel, a) : 129'h0);
            #1;
            check(tag, dut_key(sel), exp_q.pop_front());
        end
    endtask

    task automatic start_load(input int sel, input logic [127:0] k);
        @(negedge clk);
        if (sel == 1) begin load1 = 1'b1; key1 = k; end
        else          begin load0 = 1'b1; key0 = k; end
        @(posedge clk);
        #1;
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    // Counts edges after the current point until keys_ready, bounded.
    task automatic wait_ready(input int sel, input int exp_cyc, input string tag);
        int  cyc = 0;
        bit  bad_busy = 1'b0;
        logic r = 1'b0;
        while (cyc < 30 && !r) begin
            @(posedge clk);
            #1;
            cyc++;
            r = (sel == 1) ? rdy1 : rdy0;
            if (!r && ((sel == 1) ? busy1 : busy0) !== 1'b1) bad_busy = 1'b1;
        end
        check({tag, "_latency"}, 129'(cyc), 129'(exp_cyc));
        check({tag, "_busy_during"}, 129'(bad_busy), 129'(0));
        check({tag, "_busy_after"}, 129'((sel == 1) ? busy1 : busy0), 129'(0));
    endtask

    initial begin
        logic [127:0] ka, kb, kc, kd, ke;
        ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        kb = 128'h112233445566778899aabbccddeeff00;
        kc = 128'h000102030405060708090a0b0c0d0e0f;
        kd = 128'hffeeddccbbaa99887766554433221100;
        ke = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        rst = 1'b1; load0 = 1'b0; load1 = 1'b0; key0 = '0; key1 = '0; addr = '0;
        build_sbox();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        sweep(0, 1'b0, "rst_key0");
        sweep(1, 1'b0, "rst_key1");
        check("rst_busy", 129'({busy0, busy1}), 129'(0));
        check("rst_ready", 129'({rdy0, rdy1}), 129'(0));
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 A.1 on the FIPS-order instance
        start_load(0, ka);
        model_expand(0, ka);
        check("a1_busy_e0", 129'({busy0, rdy0}), 129'(2'b10));
        wait_ready(0, 10, "a1");
        sweep(0, 1'b1, "a1_sweep");
        addr = 4'd1; #1;
        check("a1_addr1", kout0, {1'b1, 128'ha0fafe1788542cb123a339392a6c7605});
        addr = 4'd10; #1;
        check("a1_addr10", kout0, {1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

        // Byte-reversed instance
        start_load(1, kb);
        model_expand(1, kb);
        wait_ready(1, 10, "rev");
        sweep(1, 1'b1, "rev_sweep");
        addr = 4'd1; #1;
        check("rev_addr1", kout1, {1'b1, brev(128'h383450856d52270df4f89cc1291663c1)});

        // Progressive valid with Addr held at 5
        addr = 4'd5;
        start_load(0, kc);
        model_expand(0, kc);
        for (int k = 0; k < 8; k++) begin
            check("prog_valid5", 129'(kout0[128]), 129'(k >= 5));
            if (k >= 5) check("prog_key5", kout0, exp_key(0, 5));
            @(posedge clk);
            #1;
        end
        addr = 4'd12; #1;
        check("prog_addr12", kout0, 129'h0);
        wait_ready(0, 2, "prog");
        sweep(0, 1'b1, "prog_sweep");

        // load during busy is ignored
        start_load(0, ka);
        model_expand(0, ka);
        repeat (2) @(posedge clk);
        @(negedge clk);
        load0 = 1'b1; key0 = kd;
        @(posedge clk);
        #1;
        load0 = 1'b0;
        wait_ready(0, 7, "busyload");
        sweep(0, 1'b1, "busyload_sweep");

        // Reload from DONE: pre-edge lookup shows old keys, then only entry 0 is valid
        addr = 4'd1;
        @(negedge clk);
        load0 = 1'b1; key0 = kd;
        #1;
        check("reload_pre_edge", kout0, exp_key(0, 1));
        @(posedge clk);
        #1;
        load0 = 1'b0;
        key0  = ke;
        model_expand(0, kd);
        check("reload_addr1_cleared", kout0, 129'h0);
        addr = 4'd0; #1;
        check("reload_addr0", kout0, exp_key(0, 0));
        wait_ready(0, 10, "reload");
        sweep(0, 1'b1, "reload_sweep");

        // Async reset mid-expansion, then a fresh load
        addr = 4'd0;
        start_load(0, ke);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_key", kout0, 129'h0);
        check("arst_flags", 129'({busy0, rdy0}), 129'(0));
        sweep(0, 1'b0, "arst_sweep");
        @(negedge clk);
        rst = 1'b0;
        start_load(0, ke);
        model_expand(0, ke);
        wait_ready(0, 10, "post_rst");
        sweep(0, 1'b1, "post_rst_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
